// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the MIPS32 instruction-fetch stage.
package fetch_stage_pkg;

    localparam int FETCH_WORD_LEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_FULL = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_hold_buffer.sv
// Single-entry skid register for a fetched word that arrived
// while ID was stalling; holds {instr, pc_plus4} plus a full flag.
module fetch_stage_hold_buffer #(
    parameter int WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                unload,
    input  logic                clear,
    input  logic [WORD_LEN-1:0] instr_in,
    input  logic [WORD_LEN-1:0] pc_plus4_in,
    output logic                full,
    output logic [WORD_LEN-1:0] instr,
    output logic [WORD_LEN-1:0] pc_plus4
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full     <= 1'b0;
            instr    <= '0;
            pc_plus4 <= '0;
        end else if (unload) begin
            full <= 1'b0;
        end else if (load) begin
            full     <= 1'b1;
            instr    <= instr_in;
            pc_plus4 <= pc_plus4_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS32 IF stage: PC, imem req/ready handshake and IF/ID register.
// Define FETCH_PERF_COUNTERS_EN to add STALL_COUNT / SQUASH_COUNT.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  WORD_LEN = FETCH_WORD_LEN,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                HAZARD_DETECTED_IN,
    input  logic                BRANCH_TAKEN,
    input  logic [WORD_LEN-1:0] BRANCH_OFFSET,
    output logic                IMEM_REQ,
    output logic [WORD_LEN-1:0] IMEM_ADDR,
    input  logic                IMEM_READY,
    input  logic [WORD_LEN-1:0] IMEM_RDATA,
    output logic [WORD_LEN-1:0] INSTRUCTION,
    output logic [WORD_LEN-1:0] PC_OUT,
    output logic                INSTR_VALID
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]         STALL_COUNT,
    output logic [31:0]         SQUASH_COUNT
`endif
);

    localparam logic [WORD_LEN-1:0] PC_STEP = WORD_LEN'(4);
    localparam logic [WORD_LEN-1:0] NOP = WORD_LEN'(NOP_INSTR);

    fetch_state_e        state_q, state_d;
    logic [WORD_LEN-1:0] pc_q, pc_d;
    logic [WORD_LEN-1:0] target_q, target_d;
    logic                squash_q, squash_d;
    logic [WORD_LEN-1:0] instr_q, instr_d;
    logic [WORD_LEN-1:0] pc_out_q, pc_out_d;
    logic                valid_q, valid_d;

    logic                stall;
    logic                br;
    logic                kill;
    logic [WORD_LEN-1:0] br_target;
    logic [WORD_LEN-1:0] pc_seq;

    logic                buf_load;
    logic                buf_unload;
    logic                buf_clear;
    logic                buf_full;
    logic [WORD_LEN-1:0] buf_instr;
    logic [WORD_LEN-1:0] buf_pc;

    assign stall     = HAZARD_DETECTED_IN;
    assign br        = BRANCH_TAKEN & ~stall;
    assign br_target = pc_out_q + (BRANCH_OFFSET << 2);
    assign pc_seq    = pc_q + PC_STEP;

    assign IMEM_REQ    = (state_q == S_REQ) & ~RESET;
    assign IMEM_ADDR   = pc_q;
    assign INSTRUCTION = instr_q;
    assign PC_OUT      = pc_out_q;
    assign INSTR_VALID = valid_q;

    fetch_stage_hold_buffer #(
        .WORD_LEN(WORD_LEN)
    ) u_hold (
        .clk        (CLK),
        .rst        (RESET),
        .load       (buf_load),
        .unload     (buf_unload),
        .clear      (buf_clear),
        .instr_in   (IMEM_RDATA),
        .pc_plus4_in(pc_seq),
        .full       (buf_full),
        .instr      (buf_instr),
        .pc_plus4   (buf_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        squash_d   = squash_q;
        target_d   = target_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        valid_d    = valid_q;
        buf_load   = 1'b0;
        buf_unload = 1'b0;
        buf_clear  = 1'b0;
        kill       = 1'b0;
        unique case (state_q)
            S_REQ: begin
                if (IMEM_READY) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        pc_d     = target_q;
                        kill     = ~stall;
                    end else if (br) begin
                        pc_d = br_target;
                        kill = 1'b1;
                    end else if (!stall) begin
                        instr_d  = IMEM_RDATA;
                        pc_out_d = pc_seq;
                        valid_d  = 1'b1;
                        pc_d     = pc_seq;
                    end else begin
                        buf_load = 1'b1;
                        pc_d     = pc_seq;
                        state_d  = S_FULL;
                    end
                end else if (br) begin
                    // Request stays on the bus; its data is dropped later.
                    squash_d = 1'b1;
                    target_d = br_target;
                    kill     = 1'b1;
                end else begin
                    kill = ~stall;
                end
            end
            S_FULL: begin
                if (br) begin
                    buf_clear = 1'b1;
                    pc_d      = br_target;
                    kill      = 1'b1;
                    state_d   = S_REQ;
                end else if (!stall) begin
                    buf_unload = 1'b1;
                    instr_d    = buf_instr;
                    pc_out_d   = buf_pc;
                    valid_d    = buf_full;
                    state_d    = S_REQ;
                end
            end
            default: ;
        endcase
        if (kill) begin
            instr_d  = NOP;
            pc_out_d = '0;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            squash_q <= 1'b0;
            target_q <= '0;
            instr_q  <= NOP;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
            target_q <= target_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic        discard;
    logic [31:0] stall_cnt_q;
    logic [31:0] squash_cnt_q;

    assign discard =
        ((state_q == S_REQ) & IMEM_READY & (squash_q | br)) |
        ((state_q == S_FULL) & br);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (discard && squash_cnt_q != '1)
                squash_cnt_q <= squash_cnt_q + 32'd1;
        end
    end

    assign STALL_COUNT  = stall_cnt_q;
    assign SQUASH_COUNT = squash_cnt_q;
`endif

endmodule
